rst_release_seq: RTL and testbench

- Produces ordered, synchronous reset releases for downstream blocks in one clock domain. Output resets are released in sequence after the PLL/MMCM reports lock and a hold time has elapsed.
- Accepts a soft-reset request via a req/ack handshake and re-runs the release sequence.
- Sits between the clocking block and per-domain logic. Each bit of RST_OUT feeds one consumer or one global-buffer-driven reset net.

---
 rtl/rst_release_seq_pkg.sv | 25 ++
 rtl/rst_release_seq_if.sv | 30 +++
 rtl/rst_release_seq_sync.sv | 28 ++
 rtl/rst_release_seq.sv | 151 +++++++++++++++
 tb/tb_rst_release_seq.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rst_release_seq_pkg.sv
// Shared definitions for the reset release sequencer.
//   state_t     : sequencer state encoding
//   max3        : largest of three integers
//   cnt_width   : bits needed to count up to the largest of three cycle counts
package rst_release_seq_pkg;

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      HOLD      = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      SOFT      = 3'd4
   } state_t;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic int cnt_width(input int a, input int b, input int c);
      return $clog2(max3(a, b, c) + 1);
   endfunction

endpackage

// File: rtl/rst_release_seq_if.sv
// Soft-reset handshake and sequenced reset outputs of rst_release_seq.
//   SOFT_RST_REQ : soft-reset request (requester -> sequencer)
//   SOFT_RST_ACK : one-cycle pulse at the end of the soft-reset hold
//   RST_OUT      : active-high per-stage resets, bit 0 releases first
//   RST_DONE     : high once every stage is released
// Modports: slave = the sequencer, master = the requester / reset consumers.
interface rst_release_seq_if #(
   parameter int N_STAGES = 3
) ();

   logic                SOFT_RST_REQ;
   logic                SOFT_RST_ACK;
   logic [N_STAGES-1:0] RST_OUT;
   logic                RST_DONE;

   modport slave (
      input  SOFT_RST_REQ,
      output SOFT_RST_ACK,
      output RST_OUT,
      output RST_DONE
   );

   modport master (
      output SOFT_RST_REQ,
      input  SOFT_RST_ACK,
      input  RST_OUT,
      input  RST_DONE
   );

endinterface

// File: rtl/rst_release_seq_sync.sv
// Two-flop synchronizer for a slow level flag crossing into CLK.
//   CLK : destination clock
//   RST : synchronous active-high reset, clears both flops to 0
//   d   : asynchronous input flag
//   q   : synchronized flag, two edges of latency
module flag_sync_2ff (
   input  logic CLK,
   input  logic RST,
   input  logic d,
   output logic q
);

   logic meta;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour; blocking here would
   // collapse the two stages into one.
   always_ff @(posedge CLK) begin
      if (RST) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/rst_release_seq.sv
// Ordered reset release sequencer.
// After the synchronized LOCKED has been high for HOLD_CYCLES cycles, RST_OUT
// bits release one at a time (bit 0 first), STAGE_GAP cycles apart; RST_DONE
// rises with the last stage. A rising edge on SOFT_RST_REQ reasserts every
// output for SOFT_PULSE cycles, pulses SOFT_RST_ACK and reruns the sequence.
//   CLK, RST : clock and synchronous active-high reset
//   LOCKED   : PLL/MMCM lock, asynchronous to CLK
//   bus      : soft-reset handshake plus RST_OUT / RST_DONE (slave modport)
module rst_release_seq
   import rst_release_seq_pkg::*;
#(
   parameter int N_STAGES    = 3,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 4,
   parameter int SOFT_PULSE  = 8
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              LOCKED,
   rst_release_seq_if.slave  bus
);

   localparam int CNT_W = cnt_width(HOLD_CYCLES, STAGE_GAP, SOFT_PULSE);
   localparam int IDX_W = $clog2(N_STAGES + 1);

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [IDX_W-1:0]    idx;
   logic [N_STAGES-1:0] rst_out_q;
   logic                done_q;
   logic                ack_q;
   logic                req_prev;
   logic                lock_s;
   logic                req_rise;

   flag_sync_2ff u_lock_sync (
      .CLK (CLK),
      .RST (RST),
      .d   (LOCKED),
      .q   (lock_s)
   );

   assign req_rise = bus.SOFT_RST_REQ & ~req_prev;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= WAIT_LOCK;
         cnt       <= '0;
         idx       <= '0;
         rst_out_q <= '1;
         done_q    <= 1'b0;
         ack_q     <= 1'b0;
         // Reset to 1 so a request held high through reset is not an edge.
         req_prev  <= 1'b1;
      end else begin
         req_prev <= bus.SOFT_RST_REQ;
         ack_q    <= 1'b0;

         // A new request wins over every other event except a request
         // arriving while already in SOFT, which is ignored.
         if (req_rise && state != SOFT) begin
            state     <= SOFT;
            cnt       <= '0;
            idx       <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
         end else begin
            case (state)
               WAIT_LOCK: begin
                  rst_out_q <= '1;
                  done_q    <= 1'b0;
                  if (lock_s) begin
                     state <= HOLD;
                     cnt   <= '0;
                  end
               end

               HOLD: begin
                  if (!lock_s) begin
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                     // Stages release in bit order, so shifting a zero in
                     // from the bottom clears exactly the next stage.
                     rst_out_q <= rst_out_q << 1;
                     cnt       <= '0;
                     idx       <= IDX_W'(1);
                     if (N_STAGES == 1) begin
                        state  <= RUN;
                        done_q <= 1'b1;
                     end else begin
                        state <= RELEASE;
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               RELEASE: begin
                  if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                     rst_out_q <= rst_out_q << 1;
                     cnt       <= '0;
                     if (idx == IDX_W'(N_STAGES - 1)) begin
                        state  <= RUN;
                        done_q <= 1'b1;
                        idx    <= '0;
                     end else begin
                        idx <= idx + IDX_W'(1);
                     end
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               RUN: begin
                  if (!lock_s) begin
                     state     <= WAIT_LOCK;
                     rst_out_q <= '1;
                     done_q    <= 1'b0;
                  end
               end

               SOFT: begin
                  // Lock loss is deliberately ignored here: the pulse always
                  // runs its full length.
                  if (cnt == CNT_W'(SOFT_PULSE - 1)) begin
                     ack_q <= 1'b1;
                     state <= WAIT_LOCK;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end

               default: begin
                  state     <= WAIT_LOCK;
                  cnt       <= '0;
                  idx       <= '0;
                  rst_out_q <= '1;
                  done_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.RST_OUT      = rst_out_q;
   assign bus.RST_DONE     = done_q;
   assign bus.SOFT_RST_ACK = ack_q;

endmodule

// File: tb/tb_rst_release_seq.sv
// Self-checking bench for rst_release_seq: directed scenarios for the main
// timing points followed by random LOCKED / SOFT_RST_REQ / RST activity, all
// compared every cycle against a time-based reference model.
module tb_rst_release_seq;

   localparam int N  = 3;
   localparam int HC = 16;
   localparam int SG = 4;
   localparam int SP = 8;

   logic clk;
   logic rst;
   logic locked;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int ack_seen = 0;

   rst_release_seq_if #(.N_STAGES(N)) bus ();

   rst_release_seq #(
      .N_STAGES    (N),
      .HOLD_CYCLES (HC),
      .STAGE_GAP   (SG),
      .SOFT_PULSE  (SP)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .LOCKED (locked),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   // Sequence progress is kept as elapsed cycles since lock qualified; each
   // stage's reset value follows directly from its release time.
   typedef enum int {M_WAIT, M_SEQ, M_RUN, M_SOFT} mode_t;
   mode_t m_mode = M_WAIT;
   int    m_e    = 0;   // cycles since the sequence started
   int    m_s    = 0;   // cycles spent in soft reset
   bit    m_sh1  = 0;
   bit    m_sh2  = 0;
   bit    m_req_prev = 1;
   bit    m_ack  = 0;

   localparam int LAST = HC + (N - 1) * SG;

   task automatic model_edge();
      bit ls;
      bit rise;
      ls   = m_sh2;
      rise = bus.SOFT_RST_REQ && !m_req_prev;
      if (rst) begin
         m_mode = M_WAIT; m_e = 0; m_s = 0;
         m_sh1 = 0; m_sh2 = 0; m_req_prev = 1; m_ack = 0;
      end else begin
         m_ack = 0;
         if (rise && m_mode != M_SOFT) begin
            m_mode = M_SOFT; m_s = 0;
         end else begin
            case (m_mode)
               M_WAIT: if (ls) begin m_mode = M_SEQ; m_e = 0; end
               M_SEQ: begin
                  if (m_e < HC && !ls) m_mode = M_WAIT;
                  else begin
                     m_e++;
                     if (m_e == LAST) m_mode = M_RUN;
                  end
               end
               M_RUN: if (!ls) m_mode = M_WAIT;
               M_SOFT: begin
                  m_s++;
                  if (m_s == SP) begin m_ack = 1; m_mode = M_WAIT; end
               end
               default: m_mode = M_WAIT;
            endcase
         end
         m_sh2      = m_sh1;
         m_sh1      = locked;
         m_req_prev = bus.SOFT_RST_REQ;
      end
   endtask

   function automatic logic [N-1:0] exp_out();
      logic [N-1:0] v;
      for (int k = 0; k < N; k++) begin
         case (m_mode)
            M_RUN:   v[k] = 1'b0;
            M_SEQ:   v[k] = (m_e < HC + k * SG);
            default: v[k] = 1'b1;
         endcase
      end
      return v;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check("rst_out",  32'(bus.RST_OUT), 32'(exp_out()));
      check("rst_done", 32'(bus.RST_DONE), 32'(m_mode == M_RUN));
      check("ack",      32'(bus.SOFT_RST_ACK), 32'(m_ack));
      if (bus.SOFT_RST_ACK === 1'b1) ack_seen++;
   endtask

   function automatic bit hit(input int what);
      case (what)
         0:       return bus.RST_OUT[0] === 1'b0;
         1:       return bus.RST_DONE === 1'b1;
         2:       return bus.SOFT_RST_ACK === 1'b1;
         3:       return bus.RST_OUT === 3'b100;
         default: return bus.RST_OUT === 3'b111;
      endcase
   endfunction

   // Steps until the condition holds; at = -1 when the budget runs out.
   task automatic wait_for(input int what, input int budget, output int at);
      at = -1;
      for (int i = 0; i < budget; i++) begin
         step();
         if (hit(what)) begin
            at = cyc;
            break;
         end
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int at;
      int mark;
      rst = 1'b1;
      locked = 1'b0;
      bus.SOFT_RST_REQ = 1'b0;

      // 1: reset state, then a clean lock and the full release timeline.
      repeat (3) step();
      check("reset_out",  32'(bus.RST_OUT), 32'h7);
      check("reset_done", 32'(bus.RST_DONE), 32'h0);
      rst = 1'b0;
      repeat (4) step();
      locked = 1'b1;
      step();
      mark = cyc;
      wait_for(0, 40, at);
      check("t1_rel0", at - mark, HC + 2);
      wait_for(3, 10, at);
      check("t1_rel1", at - mark, HC + 2 + SG);
      wait_for(1, 20, at);
      check("t1_done", at - mark, HC + 2 + 2 * SG);
      check("t1_no_ack", ack_seen, 0);

      // 2: a short lock pulse must not release anything.
      rst = 1'b1; step(); rst = 1'b0;
      repeat (10) step();
      locked = 1'b0;
      repeat (6) step();
      check("t2_no_rel", 32'(bus.RST_OUT), 32'h7);
      locked = 1'b1;
      step();
      mark = cyc;
      wait_for(0, 40, at);
      check("t2_rel0", at - mark, HC + 2);
      wait_for(1, 40, at);

      // 3: soft reset from RUN with the request held high.
      ack_seen = 0;
      bus.SOFT_RST_REQ = 1'b1;
      step();
      mark = cyc;
      check("t3_enter", 32'(bus.RST_OUT), 32'h7);
      wait_for(2, 20, at);
      check("t3_ack", at - mark, SP);
      wait_for(0, 40, at);
      check("t3_rel0", at - mark, SP + 1 + HC);
      wait_for(1, 30, at);
      repeat (20) step();
      check("t3_one_ack", ack_seen, 1);
      bus.SOFT_RST_REQ = 1'b0;
      step();

      // 4: lock loss in RUN, then recovery.
      locked = 1'b0;
      step();
      mark = cyc;
      wait_for(4, 10, at);
      check("t4_drop", at - mark, 2);
      locked = 1'b1;
      wait_for(1, 60, at);
      check("t4_rerun", 32'(at > 0), 32'h1);

      // 5: RST mid-release with the request held high.
      rst = 1'b1; step(); rst = 1'b0;
      wait_for(3, 60, at);
      check("t5_in_release", 32'(at > 0), 32'h1);
      bus.SOFT_RST_REQ = 1'b1;
      rst = 1'b1;
      step();
      check("t5_rst_out",  32'(bus.RST_OUT), 32'h7);
      check("t5_rst_ack",  32'(bus.SOFT_RST_ACK), 32'h0);
      rst = 1'b0;
      ack_seen = 0;
      repeat (40) step();
      check("t5_no_soft", ack_seen, 0);
      check("t5_done", 32'(bus.RST_DONE), 32'h1);
      bus.SOFT_RST_REQ = 1'b0;
      step();
      bus.SOFT_RST_REQ = 1'b1;
      step();
      mark = cyc;
      wait_for(2, 20, at);
      check("t5_soft_ack", at - mark, SP);
      bus.SOFT_RST_REQ = 1'b0;

      // 6: request rise on the same edge the synchronized lock loss is seen.
      wait_for(1, 60, at);
      locked = 1'b0;
      step();
      step();
      bus.SOFT_RST_REQ = 1'b1;
      step();
      mark = cyc;
      wait_for(2, 20, at);
      check("t6_ack", at - mark, SP);
      repeat (30) step();
      check("t6_waiting", 32'(bus.RST_OUT), 32'h7);
      bus.SOFT_RST_REQ = 1'b0;
      locked = 1'b1;
      wait_for(1, 60, at);
      check("t6_relock", 32'(at > 0), 32'h1);

      // Random activity, checked cycle by cycle against the model.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 39) == 0) locked = ~locked;
         if ($urandom_range(0, 29) == 0) bus.SOFT_RST_REQ = ~bus.SOFT_RST_REQ;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
